// File: rtl/knn_local_sp_arbiter.sv
// knn_local_sp_arbiter
//   Shares the single address0/ce0/we0 port of one local URAM buffer between
//   the search-space loader (write requester) and the distance pipeline (read
//   requester). Grants are combinational and commands are registered one
//   cycle before they reach the memory. Read data returns READ_LATENCY edges
//   after the handshake edge, together with its address. While idle is high,
//   no command is pending and no read is outstanding.
//
// Ports
//   clk, reset                     clock, asynchronous active-high reset
//   wr_valid/wr_ready/wr_addr/wr_data   write request channel
//   rd_valid/rd_ready/rd_addr           read request channel
//   rd_rsp_valid/rd_rsp_addr/rd_rsp_data  read response (no backpressure)
//   idle                           no issue pending and no read in flight
//   mem_address0/ce0/we0/d0/q0     URAM port
//
// Build option
//   KNN_SP_ARB_WRITE_PRIORITY_EN   when defined, the write requester always
//                                  wins a conflict and the round-robin
//                                  pointer is removed.

module knn_local_sp_arbiter #(
  parameter int DataWidth    = 256,
  parameter int AddressWidth = 11,
  parameter int READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [AddressWidth-1:0] wr_addr,
  input  logic [DataWidth-1:0]    wr_data,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [AddressWidth-1:0] rd_addr,
  output logic                    rd_rsp_valid,
  output logic [AddressWidth-1:0] rd_rsp_addr,
  output logic [DataWidth-1:0]    rd_rsp_data,
  output logic                    idle,
  output logic [AddressWidth-1:0] mem_address0,
  output logic                    mem_ce0,
  output logic                    mem_we0,
  output logic [DataWidth-1:0]    mem_d0,
  input  logic [DataWidth-1:0]    mem_q0
);

  // The outstanding count has to reach READ_LATENCY+1: a read stays counted
  // from its handshake edge until the end of its response cycle.
  localparam int CntWidth = $clog2(READ_LATENCY + 2);

  logic wr_fire;
  logic rd_fire;
  logic issued_read;

  logic [READ_LATENCY-1:0] vld_pipe;
  logic [AddressWidth-1:0] addr_pipe [READ_LATENCY];
  logic [CntWidth-1:0]     out_cnt;

  // ---------------------------------------------------------------- grant
`ifdef KNN_SP_ARB_WRITE_PRIORITY_EN
  // The loader must never stall, so reads only get the cycles it leaves free.
  assign wr_ready = wr_valid;
  assign rd_ready = rd_valid & ~wr_valid;
`else
  // last_wr is high when the write side won the most recent conflict. The
  // other side then wins the next conflict.
  logic last_wr;

  assign wr_ready = wr_valid & (~rd_valid | ~last_wr);
  assign rd_ready = rd_valid & (~wr_valid | last_wr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_wr <= 1'b0;
    end else if (wr_valid && rd_valid) begin
      last_wr <= ~last_wr;
    end
  end
`endif

  assign wr_fire = wr_valid & wr_ready;
  assign rd_fire = rd_valid & rd_ready;

  // --------------------------------------------------------- issue register
  // Address and data hold when nothing is issued, so the memory inputs stop
  // toggling. A read leaves d0 unchanged because the memory ignores it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ce0      <= 1'b0;
      mem_we0      <= 1'b0;
      mem_address0 <= '0;
      mem_d0       <= '0;
    end else begin
      mem_ce0 <= wr_fire | rd_fire;
      mem_we0 <= wr_fire;
      if (wr_fire) begin
        mem_address0 <= wr_addr;
        mem_d0       <= wr_data;
      end else if (rd_fire) begin
        mem_address0 <= rd_addr;
      end
    end
  end

  // ------------------------------------------------------- read tracking
  // The pipeline is fed from the issue register, that is, on the edge where
  // the memory samples ce0. Its tail therefore lines up with q0 when the
  // pipeline is READ_LATENCY deep.
  assign issued_read = mem_ce0 & ~mem_we0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        addr_pipe[k] <= '0;
      end
    end else begin
      vld_pipe[0]  <= issued_read;
      addr_pipe[0] <= mem_address0;
      for (int k = 1; k < READ_LATENCY; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        addr_pipe[k] <= addr_pipe[k-1];
      end
    end
  end

  assign rd_rsp_valid = vld_pipe[READ_LATENCY-1];
  assign rd_rsp_addr  = addr_pipe[READ_LATENCY-1];
  assign rd_rsp_data  = mem_q0;

  // ------------------------------------------------------ outstanding reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_cnt <= '0;
    end else begin
      case ({rd_fire, rd_rsp_valid})
        2'b10:   out_cnt <= out_cnt + CntWidth'(1);
        2'b01:   out_cnt <= out_cnt - CntWidth'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // mem_ce0 covers a write that is still in the issue register. The counter
  // does not track writes.
  assign idle = (out_cnt == '0) && !mem_ce0;

endmodule

// File: tb/tb_knn_local_sp_arbiter.sv
// Testbench for knn_local_sp_arbiter. It drives three instances with
// READ_LATENCY 2, 1 and 4 from the same request stream. A model built from
// the arbitration rules and a timestamped list of granted reads predicts
// every output of every instance in every cycle.

module tb_knn_local_sp_arbiter;

  localparam int AW = 11;
  localparam int DW = 256;
  localparam int NI = 3;

  logic          clk;
  logic          reset;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic [AW-1:0] rd_addr;

  logic          wrr       [NI];
  logic          rdr       [NI];
  logic          rsp_v     [NI];
  logic [AW-1:0] rsp_a     [NI];
  logic [DW-1:0] rsp_d     [NI];
  logic          idl       [NI];
  logic [AW-1:0] maddr     [NI];
  logic          ce        [NI];
  logic          we        [NI];
  logic [DW-1:0] md        [NI];
  logic [DW-1:0] q         [NI];

  int lat_of [NI] = '{2, 1, 4};

  // Behavioural URAM. The port of instance 0 drives the shared array. Every
  // instance issues identical commands, because the grant does not depend on
  // the latency. Each instance gets its own q0 delay line.
  logic [DW-1:0] mem [2048];

  always @(posedge clk) begin
    if (ce[0] && we[0]) mem[maddr[0]] <= md[0];
  end

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    logic [DW-1:0] qp [L];

    always @(posedge clk) begin
      if (ce[g] && !we[g]) qp[0] <= mem[maddr[g]];
      for (int k = 1; k < L; k++) qp[k] <= qp[k-1];
    end
    assign q[g] = qp[L-1];

    knn_local_sp_arbiter #(
      .DataWidth   (DW),
      .AddressWidth(AW),
      .READ_LATENCY(L)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .wr_valid    (wr_valid),
      .wr_ready    (wrr[g]),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_valid    (rd_valid),
      .rd_ready    (rdr[g]),
      .rd_addr     (rd_addr),
      .rd_rsp_valid(rsp_v[g]),
      .rd_rsp_addr (rsp_a[g]),
      .rd_rsp_data (rsp_d[g]),
      .idle        (idl[g]),
      .mem_address0(maddr[g]),
      .mem_ce0     (ce[g]),
      .mem_we0     (we[g]),
      .mem_d0      (md[g]),
      .mem_q0      (q[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------ model state
  typedef struct {
    int            gc;      // cycle in which the read was granted
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            known;   // data is checked only for addresses written earlier
  } rd_t;

  rd_t           rq [$];
  int            hd [NI];
  logic [DW-1:0] mm [2048];
  bit            written [2048];
  bit            m_last_wr;
  bit            m_ce, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            cyc;
  int            tests;
  int            fails;
  logic          last_wrr;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    for (int i = 0; i < NI; i++) hd[i] = 0;
    m_last_wr = 1'b0;
    m_ce      = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_data    = '0;
  endtask

  function automatic logic [DW-1:0] rnd256();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Each call covers one clock cycle. Inputs change just after the rising
  // edge, outputs are checked at the falling edge, and the model advances
  // after the checks.
  task automatic step(input logic r, input logic wv, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic rv, input logic [AW-1:0] ra);
    bit gw, gr, exp_v, exp_idle;
    int L;
    string t;
    @(posedge clk);
    cyc++;
    #1;
    reset    = r;
    wr_valid = wv;
    wr_addr  = wa;
    wr_data  = wd;
    rd_valid = rv;
    rd_addr  = ra;
    if (r) model_reset();

`ifdef KNN_SP_ARB_WRITE_PRIORITY_EN
    gw = wv;
    gr = rv && !wv;
`else
    if (wv && rv) begin
      gw = !m_last_wr;
      gr = m_last_wr;
    end else begin
      gw = wv;
      gr = rv;
    end
`endif

    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      L = lat_of[i];
      t = $sformatf("L%0d c%0d", L, cyc);
      chk({t, " wr_ready"}, wrr[i], gw);
      chk({t, " rd_ready"}, rdr[i], gr);
      chk({t, " mem_ce0"}, ce[i], m_ce);
      chk({t, " mem_we0"}, we[i], m_we);
      chk({t, " mem_address0"}, maddr[i], m_addr);
      if (m_we) chk({t, " mem_d0"}, md[i], m_data);
      exp_v    = (hd[i] < rq.size()) && (rq[hd[i]].gc + L + 1 == cyc);
      exp_idle = !m_ce && (hd[i] == rq.size());
      chk({t, " rd_rsp_valid"}, rsp_v[i], exp_v);
      chk({t, " idle"}, idl[i], exp_idle);
      if (exp_v) begin
        chk({t, " rd_rsp_addr"}, rsp_a[i], rq[hd[i]].addr);
        if (rq[hd[i]].known) chk({t, " rd_rsp_data"}, rsp_d[i], rq[hd[i]].data);
        hd[i]++;
      end
    end
    last_wrr = wrr[0];

    if (!r) begin
      if (wv && rv) m_last_wr = gw;
      m_ce = gw || gr;
      m_we = gw;
      if (gw) begin
        m_addr      = wa;
        m_data      = wd;
        mm[wa]      = wd;
        written[wa] = 1'b1;
      end else if (gr) begin
        m_addr = ra;
        rq.push_back('{gc: cyc, addr: ra, data: mm[ra], known: written[ra]});
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    logic [3:0] pat;
    logic [3:0] pat_exp;
    tests    = 0;
    fails    = 0;
    cyc      = 0;
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_valid = 1'b0;
    rd_addr  = '0;
    for (int a = 0; a < 2048; a++) begin
      written[a] = 1'b0;
      mm[a]      = '0;
    end
    model_reset();

    // Reset state.
    step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    idle_cycles(2);

    // Single read of 0x010.
    step(1'b0, 1'b0, '0, '0, 1'b1, 11'h010);
    idle_cycles(7);

    // Write then read the same address on the next cycle.
    step(1'b0, 1'b1, 11'h7FF, {32{8'hAA}}, 1'b0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 11'h7FF);
    idle_cycles(7);

    // Both requesters held for 4 cycles, with no earlier conflict.
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, AW'(11'h020 + k), rnd256(), 1'b1, AW'(11'h020 + k));
      pat[k] = last_wrr;
    end
`ifdef KNN_SP_ARB_WRITE_PRIORITY_EN
    pat_exp = 4'b1111;
`else
    pat_exp = 4'b0101;
`endif
    chk("rr_grant_pattern", pat, pat_exp);
    idle_cycles(7);

    // Eight back-to-back reads.
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, '0, '0, 1'b1, AW'(k));
    idle_cycles(8);

    // Two reads, then reset while they are in flight.
    step(1'b0, 1'b0, '0, '0, 1'b1, 11'h100);
    step(1'b0, 1'b0, '0, '0, 1'b1, 11'h101);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    idle_cycles(8);

    // Random traffic on a small address window, so reads hit written data.
    for (int k = 0; k < 400; k++) begin
      step(1'b0, ($urandom_range(0, 9) < 6), AW'($urandom_range(0, 31)), rnd256(),
           ($urandom_range(0, 9) < 6), AW'($urandom_range(0, 31)));
    end
    idle_cycles(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
